mac_learn_table: RTL and testbench
==================================

# mac_learn_table

Parametrised MAC learning/forwarding table for the switch datapath: learns source MAC → ingress port bindings, answers destination lookups with hit/port/flood/filter, and ages entries out with a background sweep. Sits between the frame parser (learn and lookup requests per frame) and the port arbiter (forwarding decision). Direct-mapped, hash-indexed, full-MAC tagged, fully pipelined lookup at one request per cycle.

## Interface
- pMAC_W, 48: MAC address width
- pPORTS, 4: number of switch ports; pPORT_W = $clog2(pPORTS) is derived
- pADDR_W, 8: index width; table depth pSLOTS = 2**pADDR_W
- pAGE_W, 9: age field width
- pAGE_INIT, 300: age loaded on learn, in ticks (must fit pAGE_W and be ≥ 1)
- pTICK_CYCLES, 32768: clock cycles per aging tick (≥ pSLOTS + 2)
- iclk  in  1  clock, all logic on rising edge
- irst_n  in  1  asynchronous active-low reset
- i_learn_valid  in  1  learn request, single-cycle, always accepted
- i_learn_mac  in  pMAC_W  source MAC to learn
- i_learn_port  in  pPORT_W  ingress port of that MAC
- i_lkp_valid  in  1  lookup request, always accepted
- i_lkp_mac  in  pMAC_W  destination MAC
- i_lkp_src_port  in  pPORT_W  ingress port of the frame being looked up
- o_res_valid  out  1  lookup result strobe
- o_res_hit  out  1  valid entry with matching tag
- o_res_port  out  pPORT_W  learned port on hit, 0 on miss
- o_res_flood  out  1  miss: forward to all ports except source
- o_res_filter  out  1  hit and learned port == source port: drop
- o_learn_evict  out  1  pulse: learn replaced a valid entry with a different MAC
- o_entry_count  out  pADDR_W+1  number of valid entries
- o_sweep_busy  out  1  aging sweep in progress

## Operation
- Index = XOR fold of MAC into pADDR_W-bit chunks (MSB chunk zero-padded). Entry = {valid, tag[pMAC_W], port, age[pAGE_W]}.
- Reset: all valid bits 0, all outputs 0, tick counter 0, FSM IDLE, sweep pointer 0, pending flag 0.
- Learn: writes {1, mac, port, pAGE_INIT} at index. Previous entry invalid → count +1. Previous valid, same tag → refresh (port and age updated), count unchanged. Previous valid, different tag → overwrite, count unchanged, o_learn_evict pulses.
- Lookup: hit = valid && tag == mac. Miss → flood=1, hit=0, port=0, filter=0. Hit → port, flood=0, filter = (port == src_port). Result fields are 0 whenever o_res_valid is 0.
- Tick counter counts 0..pTICK_CYCLES-1 and wraps; the tick pulse occurs on the wrap.
- Aging FSM:
  - IDLE: on tick → SWEEP with pointer 0.
  - SWEEP: each cycle with no learn, entry[pointer] is processed. If valid, age -1; an entry whose age reaches 0 is invalidated (count −1). Pointer then increments. After processing pSLOTS−1 → IDLE, or → SWEEP from 0 if the pending flag is set (flag cleared).
  - A tick during SWEEP sets the pending flag. Ticks are never lost but are not queued beyond 1.
- Learn in a SWEEP cycle: learn wins and the sweep stalls (pointer holds). Applies even if both target the same index.
- Count arithmetic is saturating in both directions. It never exceeds pSLOTS and never goes below 0.
- Asserting irst_n low mid-sweep or mid-lookup: immediate return to the reset state. In-flight lookups are discarded; o_res_valid is 0.

## Timing
- Learn presented in cycle t is committed at the end of cycle t. o_learn_evict and o_entry_count update in cycle t+1.
- Lookup presented in cycle t produces o_res_valid in cycle t+2 (2-cycle latency, no bubbles, back-to-back accepted).
- Lookup reads the table state at the start of cycle t+1:
  - includes learns from cycle t and earlier;
  - excludes learns from cycle t+1.
- Sweep with no learn stalls takes exactly pSLOTS cycles. o_sweep_busy is high from the cycle after the tick through the last processed entry.
- Age decrement and invalidation are visible to lookups issued in the cycle after processing.
- Simultaneous learn and lookup to the same MAC in cycle t: the lookup hits.

## Test plan
- Reset, then lookup 00:11:22:33:44:55 from port 1 → cycle t+2: valid=1, hit=0, flood=1, port=0, count=0.
- Learn 00:11:22:33:44:55 on port 2 (index 0x11), then lookup from port 1 → hit=1, port=2, flood=0, filter=0, count=1. The same lookup from port 2 → filter=1.
- Learn 00:00:00:00:00:11 on port 3 (same index 0x11) → o_learn_evict=1 next cycle, count stays 1. Lookup of the old MAC → miss/flood; lookup of the new MAC → hit, port 3.
- Aging (pADDR_W=4, pAGE_INIT=3, pTICK_CYCLES=64): learn one MAC, run 3 ticks plus sweeps → after the 3rd sweep the lookup misses and count=0. A re-learn between ticks 2 and 3 keeps it alive, so the lookup hits.
- Learn every cycle during a sweep → pointer holds and o_sweep_busy stays high. After learns stop, the sweep completes in the remaining entry count of cycles. A tick during the sweep sets pending, and a second sweep runs back-to-back.
- Assert irst_n mid-sweep with 5 lookups in flight → no o_res_valid, count=0, o_sweep_busy=0. A post-reset lookup of a previously learned MAC misses.

Source files
------------

// File: rtl/mac_learn_table.sv
// rtl/mac_learn_table.sv - hash-indexed MAC learning table with pipelined lookup and aging sweep
module mac_learn_table #(
    parameter int pMAC_W       = 48,
    parameter int pPORTS       = 4,
    parameter int pADDR_W      = 8,
    parameter int pAGE_W       = 9,
    parameter int pAGE_INIT    = 300,
    parameter int pTICK_CYCLES = 32768,
    localparam int pPORT_W     = $clog2(pPORTS)
) (
    input  logic               iclk,
    input  logic               irst_n,
    input  logic               i_learn_valid,
    input  logic [pMAC_W-1:0]  i_learn_mac,
    input  logic [pPORT_W-1:0] i_learn_port,
    input  logic               i_lkp_valid,
    input  logic [pMAC_W-1:0]  i_lkp_mac,
    input  logic [pPORT_W-1:0] i_lkp_src_port,
    output logic               o_res_valid,
    output logic               o_res_hit,
    output logic [pPORT_W-1:0] o_res_port,
    output logic               o_res_flood,
    output logic               o_res_filter,
    output logic               o_learn_evict,
    output logic [pADDR_W:0]   o_entry_count,
    output logic               o_sweep_busy
);
    localparam int pSLOTS  = 2 ** pADDR_W;
    localparam int pTICK_W = $clog2(pTICK_CYCLES);
    localparam logic [pADDR_W:0]   COUNT_MAX = (pADDR_W + 1)'(pSLOTS);
    localparam logic [pTICK_W-1:0] TICK_LAST = pTICK_W'(pTICK_CYCLES - 1);
    localparam logic [pAGE_W-1:0]  AGE_LOAD  = pAGE_W'(pAGE_INIT);

    typedef enum logic {IDLE, SWEEP} state_t;

    // XOR fold: bit i of the MAC lands on index bit (i mod pADDR_W)
    function automatic logic [pADDR_W-1:0] fold_index(input logic [pMAC_W-1:0] mac);
        logic [pADDR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < pMAC_W; i++) idx[i % pADDR_W] ^= mac[i];
        return idx;
    endfunction

    // table storage; only valid bits need a reset
    logic [pSLOTS-1:0]  valid_q, valid_d;
    logic [pMAC_W-1:0]  tag_mem  [pSLOTS];
    logic [pPORT_W-1:0] port_mem [pSLOTS];
    logic [pAGE_W-1:0]  age_mem  [pSLOTS];

    logic               mem_we;
    logic [pADDR_W-1:0] mem_idx;
    logic [pMAC_W-1:0]  mem_tag;
    logic [pPORT_W-1:0] mem_port;
    logic [pAGE_W-1:0]  mem_age;

    logic [pADDR_W:0]   count_q, count_d;
    logic               evict_q, evict_d;
    logic [pTICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic               tick;
    state_t             state_q, state_d;
    logic [pADDR_W-1:0] ptr_q, ptr_d;
    logic               pending_q, pending_d;

    logic               lkp_valid_q;
    logic [pMAC_W-1:0]  lkp_mac_q;
    logic [pPORT_W-1:0] lkp_src_q;
    logic [pADDR_W-1:0] learn_idx, lkp_idx;
    logic               lkp_hit;

    logic               res_valid_q, res_valid_d;
    logic               res_hit_q, res_hit_d;
    logic [pPORT_W-1:0] res_port_q, res_port_d;
    logic               res_flood_q, res_flood_d;
    logic               res_filter_q, res_filter_d;

    // free-running tick counter; the tick is the wrap cycle
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        learn_idx  = fold_index(i_learn_mac);
        lkp_idx    = fold_index(lkp_mac_q);
    end

    // table update: a learn takes the write port, otherwise the sweep ages entry[ptr]
    always_comb begin
        valid_d  = valid_q;
        count_d  = count_q;
        evict_d  = 1'b0;
        mem_we   = 1'b0;
        mem_idx  = learn_idx;
        mem_tag  = i_learn_mac;
        mem_port = i_learn_port;
        mem_age  = AGE_LOAD;
        if (i_learn_valid) begin
            mem_we = 1'b1;
            if (!valid_q[learn_idx]) begin
                count_d = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
            end else if (tag_mem[learn_idx] != i_learn_mac) begin
                evict_d = 1'b1;
            end
            valid_d[learn_idx] = 1'b1;
        end else if (state_q == SWEEP && valid_q[ptr_q]) begin
            mem_we   = 1'b1;
            mem_idx  = ptr_q;
            mem_tag  = tag_mem[ptr_q];
            mem_port = port_mem[ptr_q];
            mem_age  = (age_mem[ptr_q] == '0) ? '0 : age_mem[ptr_q] - 1'b1;
            if (age_mem[ptr_q] <= 1) begin
                valid_d[ptr_q] = 1'b0;
                count_d = (count_q == '0) ? count_q : count_q - 1'b1;
            end
        end
    end

    // aging FSM: one sweep per tick, at most one tick remembered while sweeping
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                if (tick) pending_d = 1'b1;
                if (!i_learn_valid) begin
                    if (ptr_q == '1) begin
                        ptr_d = '0;
                        if (pending_q || tick) pending_d = pending_q && tick;
                        else state_d = IDLE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // lookup stage 2: compare against the table as committed at the end of the request cycle
    always_comb begin
        lkp_hit      = lkp_valid_q && valid_q[lkp_idx] && (tag_mem[lkp_idx] == lkp_mac_q);
        res_valid_d  = lkp_valid_q;
        res_hit_d    = lkp_hit;
        res_port_d   = lkp_hit ? port_mem[lkp_idx] : '0;
        res_flood_d  = lkp_valid_q && !lkp_hit;
        res_filter_d = lkp_hit && (port_mem[lkp_idx] == lkp_src_q);
    end

    // entry payload write port
    always_ff @(posedge iclk) begin
        if (mem_we) begin
            tag_mem[mem_idx]  <= mem_tag;
            port_mem[mem_idx] <= mem_port;
            age_mem[mem_idx]  <= mem_age;
        end
    end

    // control and pipeline registers
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            valid_q      <= '0;
            count_q      <= '0;
            evict_q      <= 1'b0;
            tick_cnt_q   <= '0;
            state_q      <= IDLE;
            ptr_q        <= '0;
            pending_q    <= 1'b0;
            lkp_valid_q  <= 1'b0;
            lkp_mac_q    <= '0;
            lkp_src_q    <= '0;
            res_valid_q  <= 1'b0;
            res_hit_q    <= 1'b0;
            res_port_q   <= '0;
            res_flood_q  <= 1'b0;
            res_filter_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            count_q      <= count_d;
            evict_q      <= evict_d;
            tick_cnt_q   <= tick_cnt_d;
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pending_q    <= pending_d;
            lkp_valid_q  <= i_lkp_valid;
            lkp_mac_q    <= i_lkp_mac;
            lkp_src_q    <= i_lkp_src_port;
            res_valid_q  <= res_valid_d;
            res_hit_q    <= res_hit_d;
            res_port_q   <= res_port_d;
            res_flood_q  <= res_flood_d;
            res_filter_q <= res_filter_d;
        end
    end

    assign o_res_valid   = res_valid_q;
    assign o_res_hit     = res_hit_q;
    assign o_res_port    = res_port_q;
    assign o_res_flood   = res_flood_q;
    assign o_res_filter  = res_filter_q;
    assign o_learn_evict = evict_q;
    assign o_entry_count = count_q;
    assign o_sweep_busy  = (state_q == SWEEP);
endmodule

// File: tb/tb_mac_learn_table.sv
// tb/tb_mac_learn_table.sv - randomized scoreboard bench for mac_learn_table
module tb_mac_learn_table;
    localparam int MAC_W = 48, PORTS = 4, PORT_W = 2, ADDR_W = 4, AGE_W = 9;
    localparam int AGE_INIT = 3, TICK = 64, SLOTS = 16;

    logic              iclk = 1'b0;
    logic              irst_n;
    logic              i_learn_valid, i_lkp_valid;
    logic [MAC_W-1:0]  i_learn_mac, i_lkp_mac;
    logic [PORT_W-1:0] i_learn_port, i_lkp_src_port;
    logic              o_res_valid, o_res_hit, o_res_flood, o_res_filter, o_learn_evict, o_sweep_busy;
    logic [PORT_W-1:0] o_res_port;
    logic [ADDR_W:0]   o_entry_count;

    always #5 iclk = ~iclk;

    mac_learn_table #(
        .pMAC_W(MAC_W), .pPORTS(PORTS), .pADDR_W(ADDR_W), .pAGE_W(AGE_W),
        .pAGE_INIT(AGE_INIT), .pTICK_CYCLES(TICK)
    ) dut (
        .iclk(iclk), .irst_n(irst_n),
        .i_learn_valid(i_learn_valid), .i_learn_mac(i_learn_mac), .i_learn_port(i_learn_port),
        .i_lkp_valid(i_lkp_valid), .i_lkp_mac(i_lkp_mac), .i_lkp_src_port(i_lkp_src_port),
        .o_res_valid(o_res_valid), .o_res_hit(o_res_hit), .o_res_port(o_res_port),
        .o_res_flood(o_res_flood), .o_res_filter(o_res_filter), .o_learn_evict(o_learn_evict),
        .o_entry_count(o_entry_count), .o_sweep_busy(o_sweep_busy)
    );

    typedef struct { int due; int hit; int port; int flood; int filter; } res_t;
    typedef struct { int count; int evict; int busy; } stat_t;
    res_t  res_q[$];
    stat_t stat_q[$];
    int n_checks = 0, n_fail = 0;
    int cyc = 0;

    always @(posedge iclk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: table as plain arrays, aging as a sweep position plus owed-tick count
    bit              m_valid[SLOTS];
    logic [MAC_W-1:0] m_tag[SLOTS];
    int              m_port[SLOTS], m_age[SLOTS];
    int              m_count, m_phase, m_ptr, m_owed;
    bit              m_sweep;

    function automatic int idx_of(input logic [MAC_W-1:0] mac);
        int r = 0;
        for (int k = 0; k < (MAC_W + ADDR_W - 1) / ADDR_W; k++)
            r ^= int'((mac >> (k * ADDR_W)) % SLOTS);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) m_valid[i] = 0;
        m_count = 0; m_phase = 0; m_ptr = 0; m_owed = 0; m_sweep = 0;
    endtask

    task automatic model_step(input bit lv, input logic [MAC_W-1:0] lm, input int lp,
                              input bit kv, input logic [MAC_W-1:0] km, input int ks);
        bit tick;
        int ev, i, owed;
        res_t r;
        tick = (m_phase == TICK - 1);
        m_phase = (m_phase + 1) % TICK;
        ev = 0;
        if (lv) begin
            i = idx_of(lm);
            if (!m_valid[i]) m_count = (m_count < SLOTS) ? m_count + 1 : SLOTS;
            else if (m_tag[i] != lm) ev = 1;
            m_valid[i] = 1; m_tag[i] = lm; m_port[i] = lp; m_age[i] = AGE_INIT;
        end else if (m_sweep && m_valid[m_ptr]) begin
            m_age[m_ptr]--;
            if (m_age[m_ptr] == 0) begin
                m_valid[m_ptr] = 0;
                m_count = (m_count > 0) ? m_count - 1 : 0;
            end
        end
        if (!m_sweep) begin
            if (tick) begin m_sweep = 1; m_ptr = 0; end
        end else begin
            owed = m_owed + int'(tick);
            if (!lv) begin
                if (m_ptr == SLOTS - 1) begin
                    if (owed > 0) begin m_ptr = 0; owed--; end
                    else m_sweep = 0;
                end else m_ptr++;
            end
            m_owed = (owed > 1) ? 1 : owed;
        end
        stat_q.push_back('{m_count, ev, int'(m_sweep)});
        if (kv) begin
            i = idx_of(km);
            r.due = cyc + 2;
            r.hit = int'(m_valid[i] && m_tag[i] == km);
            r.port = r.hit ? m_port[i] : 0;
            r.flood = !r.hit;
            r.filter = r.hit && (m_port[i] == ks);
            res_q.push_back(r);
        end
    endtask

    // one clock of stimulus; called just after a rising edge
    task automatic step(input bit lv, input logic [MAC_W-1:0] lm, input int lp,
                        input bit kv, input logic [MAC_W-1:0] km, input int ks);
        i_learn_valid = lv; i_learn_mac = lm; i_learn_port = PORT_W'(lp);
        i_lkp_valid = kv; i_lkp_mac = km; i_lkp_src_port = PORT_W'(ks);
        model_step(lv, lm, lp, kv, km, ks);
        @(posedge iclk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, 0);
    endtask

    task automatic do_reset(input int n);
        irst_n = 1'b0;
        i_learn_valid = 0; i_learn_mac = '0; i_learn_port = '0;
        i_lkp_valid = 0; i_lkp_mac = '0; i_lkp_src_port = '0;
        res_q.delete(); stat_q.delete();
        model_reset();
        repeat (n) @(posedge iclk);
        #1;
        stat_q.push_back('{0, 0, 0});
        irst_n = 1'b1;
    endtask

    task automatic wait_sweep();
        for (int i = 0; i < 4 * TICK && !m_sweep; i++) idle(1);
    endtask

    // monitor: status every cycle, results whenever the DUT strobes one
    always @(negedge iclk) begin
        stat_t s;
        res_t r;
        if (irst_n === 1'b0) begin
            chk("rst_res_valid", o_res_valid, 0);
            chk("rst_count", o_entry_count, 0);
            chk("rst_busy", o_sweep_busy, 0);
            chk("rst_evict", o_learn_evict, 0);
        end else if (irst_n === 1'b1) begin
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                chk("entry_count", o_entry_count, s.count);
                chk("learn_evict", o_learn_evict, s.evict);
                chk("sweep_busy", o_sweep_busy, s.busy);
            end
            if (o_res_valid) begin
                if (res_q.size() == 0) chk("unexpected_res", 1, 0);
                else begin
                    r = res_q.pop_front();
                    chk("res_latency", cyc, r.due);
                    chk("res_hit", o_res_hit, r.hit);
                    chk("res_port", o_res_port, r.port);
                    chk("res_flood", o_res_flood, r.flood);
                    chk("res_filter", o_res_filter, r.filter);
                end
            end else begin
                chk("idle_fields", {o_res_hit, o_res_flood, o_res_filter, o_res_port}, 0);
                if (res_q.size() > 0 && res_q[0].due <= cyc) begin
                    chk("missing_res", 0, 1);
                    void'(res_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [MAC_W-1:0] mac_a, mac_b, mac_c, pool[24];
        mac_a = 48'h001122334455;
        mac_b = 48'h000000000011;
        mac_c = 48'h0a0b0c0d0e0f;
        for (int i = 0; i < 24; i++) pool[i] = {16'($urandom), 32'($urandom)};
        irst_n = 1'b1;
        do_reset(3);

        // miss on empty table, then learn / hit / filter
        step(0, '0, 0, 1, mac_a, 1);
        idle(3);
        step(1, mac_a, 2, 1, mac_a, 1);
        step(0, '0, 0, 1, mac_a, 1);
        step(0, '0, 0, 1, mac_a, 2);
        idle(3);
        // colliding learn evicts the old MAC
        step(1, mac_b, 3, 0, '0, 0);
        step(0, '0, 0, 1, mac_a, 1);
        step(0, '0, 0, 1, mac_b, 0);
        idle(3);

        // aging: mac_c dies after three sweeps; mac_b is refreshed along the way
        step(1, mac_c, 1, 0, '0, 0);
        for (int i = 0; i < 4 * TICK; i++) begin
            if (i == 2 * TICK + 10) step(1, mac_b, 0, 0, '0, 0);
            else step(0, '0, 0, (i % 8) == 0, (i % 16) ? mac_c : mac_b, 2);
        end

        // fill all slots to check count saturation at the top
        for (int k = 0; k < SLOTS; k++) step(1, MAC_W'(k), k % PORTS, 0, '0, 0);
        for (int k = 0; k < SLOTS; k++) step(1, MAC_W'(k), (k + 1) % PORTS, 1, MAC_W'(k), k % PORTS);
        step(1, 48'h000000000105, 1, 1, 48'h000000000005, 0);
        idle(3);

        // continuous learns during a sweep, long enough to cross a tick
        wait_sweep();
        for (int i = 0; i < 80; i++) step(1, pool[$urandom_range(23)], $urandom_range(3), 1, pool[$urandom_range(23)], $urandom_range(3));
        idle(2 * TICK);

        // random mix
        for (int i = 0; i < 600; i++)
            step(($urandom % 3) == 0, pool[$urandom_range(23)], $urandom_range(3),
                 ($urandom % 2) == 0, pool[$urandom_range(23)], $urandom_range(3));
        idle(3);

        // reset mid-sweep with lookups in flight
        step(1, mac_c, 3, 0, '0, 0);
        wait_sweep();
        for (int i = 0; i < 5; i++) step(0, '0, 0, 1, mac_c, 0);
        do_reset(3);
        step(0, '0, 0, 1, mac_c, 0);
        idle(4);
        chk("drain", res_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
